// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer slice: index width, entry-type codes and entry record.
package reorder_buffer_pkg;

  localparam int unsigned RoB_WIDTH = 3;
  localparam int unsigned RoB_SIZE  = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH:0] NON_DEP = 1 << RoB_WIDTH;

  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_BRANCH = 2'd1,
    ROB_TYPE_STORE  = 2'd2,
    ROB_TYPE_JALR   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   kind;
    logic [4:0]  rd;
    logic        pred;
    logic        taken;
    logic [31:0] value;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatcher / CDB / RF-commit bundle of the reorder buffer; slave is the RoB side.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic                 issue_valid;
  logic [1:0]           issue_type;
  logic [4:0]           issue_rd;
  logic                 issue_pred_taken;
  logic                 issue_ready;
  logic [31:0]          issue_value;
  logic                 rob_full;
  logic [RoB_WIDTH-1:0] rob_tail;

  logic                 cdb_valid;
  logic [RoB_WIDTH-1:0] cdb_index;
  logic [31:0]          cdb_value;
  logic                 cdb_taken;
  logic [31:0]          cdb_target;

  logic [RoB_WIDTH-1:0] q1_index;
  logic [RoB_WIDTH-1:0] q2_index;
  logic                 q1_ready;
  logic                 q2_ready;
  logic [31:0]          q1_value;
  logic [31:0]          q2_value;

  logic                 rf_update_en;
  logic [4:0]           rf_update_reg;
  logic [RoB_WIDTH-1:0] rf_update_index;
  logic [31:0]          rf_update_data;
  logic                 store_commit_en;
  logic                 flush_signal;
  logic [31:0]          flush_pc;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pred_taken, issue_ready, issue_value,
    output cdb_valid, cdb_index, cdb_value, cdb_taken, cdb_target,
    output q1_index, q2_index,
    input  rob_full, rob_tail, q1_ready, q2_ready, q1_value, q2_value,
    input  rf_update_en, rf_update_reg, rf_update_index, rf_update_data,
    input  store_commit_en, flush_signal, flush_pc
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pred_taken, issue_ready, issue_value,
    input  cdb_valid, cdb_index, cdb_value, cdb_taken, cdb_target,
    input  q1_index, q2_index,
    output rob_full, rob_tail, q1_ready, q2_ready, q1_value, q2_value,
    output rf_update_en, rf_update_reg, rf_update_index, rf_update_data,
    output store_commit_en, flush_signal, flush_pc
  );

endinterface

// File: rtl/rob_query_port.sv
// One Dispatcher operand lookup: a same-cycle CDB broadcast to the queried entry wins over stored state.
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  logic                 cdb_valid,
  input  logic [RoB_WIDTH-1:0] cdb_index,
  input  logic [31:0]          cdb_value,
  input  logic [RoB_WIDTH-1:0] q_index,
  input  logic                 entry_busy,
  input  logic                 entry_ready,
  input  logic [31:0]          entry_value,
  output logic                 q_ready,
  output logic [31:0]          q_value
);

  always_comb begin
    q_ready = 1'b0;
    q_value = '0;
    if (cdb_valid && cdb_index == q_index) begin
      q_ready = 1'b1;
      q_value = cdb_value;
    end else if (entry_busy && entry_ready) begin
      q_ready = 1'b1;
      q_value = entry_value;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocate at tail, complete via CDB, retire/flush from head.
// Optional ROB_PERF_COUNTER_EN adds commit_count / flush_count outputs.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  reorder_buffer_if.slave rob_bus
`ifdef ROB_PERF_COUNTER_EN
  ,
  output logic [31:0] commit_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [RoB_WIDTH:0] COUNT_FULL = RoB_SIZE[RoB_WIDTH:0];

  rob_entry_t           entry_q [RoB_SIZE];
  rob_entry_t           entry_d [RoB_SIZE];
  logic [RoB_WIDTH-1:0] head_q, head_d;
  logic [RoB_WIDTH-1:0] tail_q, tail_d;
  logic [RoB_WIDTH:0]   count_q, count_d;
  logic                 flush_q, flush_d;
  logic [31:0]          flush_pc_q, flush_pc_d;

  rob_entry_t head_e;
  logic       full;
  logic       flushing;
  logic       active;
  logic       commit;
  logic       alloc;
  logic       cdb_hit;
  logic       mispredict;

  always_comb begin
    head_e     = entry_q[head_q];
    full       = (count_q == COUNT_FULL);
    flushing   = flush_q && rdy_in;
    active     = rdy_in && !flush_q;
    commit     = active && head_e.busy && head_e.ready;
    alloc      = active && rob_bus.issue_valid && !full;
    cdb_hit    = active && rob_bus.cdb_valid && entry_q[rob_bus.cdb_index].busy;
    mispredict = commit &&
                 ((head_e.kind == ROB_TYPE_BRANCH && head_e.taken != head_e.pred) ||
                  (head_e.kind == ROB_TYPE_JALR && head_e.taken));
  end

  // Order matters: CDB update, then allocation, then head release. Head and tail only
  // coincide when empty (no commit) or full (no alloc), so these never collide.
  always_comb begin
    entry_d    = entry_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;
    if (flushing) begin
      for (int unsigned i = 0; i < RoB_SIZE; i++) entry_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      flush_d = 1'b0;
    end else begin
      if (cdb_hit) begin
        entry_d[rob_bus.cdb_index].ready  = 1'b1;
        entry_d[rob_bus.cdb_index].value  = rob_bus.cdb_value;
        entry_d[rob_bus.cdb_index].taken  = rob_bus.cdb_taken;
        entry_d[rob_bus.cdb_index].target = rob_bus.cdb_target;
      end
      if (alloc) begin
        entry_d[tail_q].busy   = 1'b1;
        entry_d[tail_q].ready  = rob_bus.issue_ready;
        entry_d[tail_q].kind   = rob_type_e'(rob_bus.issue_type);
        entry_d[tail_q].rd     = rob_bus.issue_rd;
        entry_d[tail_q].pred   = rob_bus.issue_pred_taken;
        entry_d[tail_q].taken  = 1'b0;
        entry_d[tail_q].value  = rob_bus.issue_value;
        entry_d[tail_q].target = '0;
        tail_d = tail_q + 1'b1;
      end
      if (commit) begin
        entry_d[head_q].busy  = 1'b0;
        entry_d[head_q].ready = 1'b0;
        head_d = head_q + 1'b1;
        if (mispredict) begin
          flush_d    = 1'b1;
          flush_pc_d = head_e.target;
        end
      end
      count_d = count_q + {{RoB_WIDTH{1'b0}}, alloc} - {{RoB_WIDTH{1'b0}}, commit};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < RoB_SIZE; i++) entry_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      entry_q    <= entry_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  always_comb begin
    rob_bus.rob_full        = full;
    rob_bus.rob_tail        = tail_q;
    rob_bus.rf_update_en    = commit;
    rob_bus.rf_update_reg   = '0;
    rob_bus.rf_update_index = '0;
    rob_bus.rf_update_data  = '0;
    rob_bus.store_commit_en = commit && head_e.kind == ROB_TYPE_STORE;
    rob_bus.flush_signal    = flushing;
    rob_bus.flush_pc        = flush_pc_q;
    if (commit) begin
      rob_bus.rf_update_index = head_q;
      rob_bus.rf_update_data  = head_e.value;
      if (head_e.kind == ROB_TYPE_REG || head_e.kind == ROB_TYPE_JALR)
        rob_bus.rf_update_reg = head_e.rd;
    end
  end

  rob_query_port u_q1 (
    .cdb_valid   (rob_bus.cdb_valid),
    .cdb_index   (rob_bus.cdb_index),
    .cdb_value   (rob_bus.cdb_value),
    .q_index     (rob_bus.q1_index),
    .entry_busy  (entry_q[rob_bus.q1_index].busy),
    .entry_ready (entry_q[rob_bus.q1_index].ready),
    .entry_value (entry_q[rob_bus.q1_index].value),
    .q_ready     (rob_bus.q1_ready),
    .q_value     (rob_bus.q1_value)
  );

  rob_query_port u_q2 (
    .cdb_valid   (rob_bus.cdb_valid),
    .cdb_index   (rob_bus.cdb_index),
    .cdb_value   (rob_bus.cdb_value),
    .q_index     (rob_bus.q2_index),
    .entry_busy  (entry_q[rob_bus.q2_index].busy),
    .entry_ready (entry_q[rob_bus.q2_index].ready),
    .entry_value (entry_q[rob_bus.q2_index].value),
    .q_ready     (rob_bus.q2_ready),
    .q_value     (rob_bus.q2_value)
  );

`ifdef ROB_PERF_COUNTER_EN
  logic [31:0] commit_count_q, commit_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    commit_count_d = commit_count_q + {31'd0, commit};
    flush_count_d  = flush_count_q + {31'd0, flushing};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      commit_count_q <= '0;
      flush_count_q  <= '0;
    end else begin
      commit_count_q <= commit_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign commit_count = commit_count_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: per-cycle vector table plus multi-cycle sequences.
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  reorder_buffer_if bus ();

`ifdef ROB_PERF_COUNTER_EN
  logic [31:0] commit_count, flush_count;
`endif

  reorder_buffer dut (
    .clk_in  (clk),
    .rst_in  (rst),
    .rdy_in  (rdy),
    .rob_bus (bus)
`ifdef ROB_PERF_COUNTER_EN
    ,
    .commit_count (commit_count),
    .flush_count  (flush_count)
`endif
  );

  typedef struct {
    logic        iv;
    logic [1:0]  ity;
    logic [4:0]  ird;
    logic        ipred;
    logic        irdy;
    logic [31:0] ival;
    logic        cv;
    logic [2:0]  cidx;
    logic [31:0] cval;
    logic        ctk;
    logic [31:0] ctgt;
    logic [2:0]  q1;
    logic        rdy;
    logic        e_full;
    logic [2:0]  e_tail;
    logic        e_upd;
    logic [4:0]  e_reg;
    logic [2:0]  e_idx;
    logic [31:0] e_data;
    logic        e_st;
    logic        e_fl;
    logic [31:0] e_fpc;
    logic        e_qr;
    logic [31:0] e_qv;
  } vec_t;

  vec_t vec [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.issue_valid      = 1'b0;
    bus.issue_type       = 2'd0;
    bus.issue_rd         = 5'd0;
    bus.issue_pred_taken = 1'b0;
    bus.issue_ready      = 1'b0;
    bus.issue_value      = '0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_index        = '0;
    bus.cdb_value        = '0;
    bus.cdb_taken        = 1'b0;
    bus.cdb_target       = '0;
    bus.q1_index         = '0;
    bus.q2_index         = '0;
    rdy                  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue(input logic [1:0] ty, input logic [4:0] rd, input logic pred,
                       input logic rv, input logic [31:0] val);
    bus.issue_valid      = 1'b1;
    bus.issue_type       = ty;
    bus.issue_rd         = rd;
    bus.issue_pred_taken = pred;
    bus.issue_ready      = rv;
    bus.issue_value      = val;
  endtask

  task automatic cdb(input logic [2:0] idx, input logic [31:0] val, input logic tk,
                     input logic [31:0] tgt);
    bus.cdb_valid  = 1'b1;
    bus.cdb_index  = idx;
    bus.cdb_value  = val;
    bus.cdb_taken  = tk;
    bus.cdb_target = tgt;
  endtask

  initial begin
    //           iv ty ird pr ir ival        cv ci cval        tk ctgt        q1 rdy  full tail upd reg idx data        st fl fpc         qr qv
    vec[0]  = '{0, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   0,   0,  0,  0,  32'h0,      0, 0, 32'h0,      0, 32'h0};
    vec[1]  = '{1, 0, 5,  0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   0,   0,  0,  0,  32'h0,      0, 0, 32'h0,      0, 32'h0};
    vec[2]  = '{0, 0, 0,  0, 0, 32'h0,      1, 0, 32'h1234,   0, 32'h0,      0, 1,   0,   1,   0,  0,  0,  32'h0,      0, 0, 32'h0,      1, 32'h1234};
    vec[3]  = '{0, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   1,   1,  5,  0,  32'h1234,   0, 0, 32'h0,      1, 32'h1234};
    vec[4]  = '{0, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   1,   0,  0,  0,  32'h0,      0, 0, 32'h0,      0, 32'h0};
    vec[5]  = '{1, 2, 0,  0, 1, 32'hAA,     0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   1,   0,  0,  0,  32'h0,      0, 0, 32'h0,      0, 32'h0};
    vec[6]  = '{0, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   2,   1,  0,  1,  32'hAA,     1, 0, 32'h0,      0, 32'h0};
    vec[7]  = '{1, 0, 7,  0, 1, 32'h55,     0, 0, 32'h0,      0, 32'h0,      0, 0,   0,   2,   0,  0,  0,  32'h0,      0, 0, 32'h0,      0, 32'h0};
    vec[8]  = '{0, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   2,   0,  0,  0,  32'h0,      0, 0, 32'h0,      0, 32'h0};
    vec[9]  = '{0, 0, 0,  0, 0, 32'h0,      1, 2, 32'hBEEF,   0, 32'h0,      2, 1,   0,   2,   0,  0,  0,  32'h0,      0, 0, 32'h0,      1, 32'hBEEF};
    vec[10] = '{1, 3, 1,  0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   2,   0,  0,  0,  32'h0,      0, 0, 32'h0,      0, 32'h0};
    vec[11] = '{0, 0, 0,  0, 0, 32'h0,      1, 2, 32'h100,    1, 32'h200,    2, 1,   0,   3,   0,  0,  0,  32'h0,      0, 0, 32'h0,      1, 32'h100};
    vec[12] = '{0, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2, 1,   0,   3,   1,  1,  2,  32'h100,    0, 0, 32'h0,      1, 32'h100};
    vec[13] = '{1, 0, 4,  0, 1, 32'h9,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   3,   0,  0,  0,  32'h0,      0, 1, 32'h200,    0, 32'h0};
    vec[14] = '{0, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   0,   0,  0,  0,  32'h0,      0, 0, 32'h0,      0, 32'h0};
    vec[15] = '{1, 0, 4,  0, 1, 32'h9,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   0,   0,  0,  0,  32'h0,      0, 0, 32'h0,      0, 32'h0};
    vec[16] = '{0, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 1,   0,   1,   1,  4,  0,  32'h9,      0, 0, 32'h0,      1, 32'h9};

    do_reset();

    // Table-driven: basic commit, store, rdy_in gating, query bypass, JALR flush.
    for (int i = 0; i < 17; i++) begin
      bus.issue_valid      = vec[i].iv;
      bus.issue_type       = vec[i].ity;
      bus.issue_rd         = vec[i].ird;
      bus.issue_pred_taken = vec[i].ipred;
      bus.issue_ready      = vec[i].irdy;
      bus.issue_value      = vec[i].ival;
      bus.cdb_valid        = vec[i].cv;
      bus.cdb_index        = vec[i].cidx;
      bus.cdb_value        = vec[i].cval;
      bus.cdb_taken        = vec[i].ctk;
      bus.cdb_target       = vec[i].ctgt;
      bus.q1_index         = vec[i].q1;
      rdy                  = vec[i].rdy;
      #1;
      chk($sformatf("v%0d rob_full", i),        32'(bus.rob_full),        32'(vec[i].e_full));
      chk($sformatf("v%0d rob_tail", i),        32'(bus.rob_tail),        32'(vec[i].e_tail));
      chk($sformatf("v%0d rf_update_en", i),    32'(bus.rf_update_en),    32'(vec[i].e_upd));
      chk($sformatf("v%0d rf_update_reg", i),   32'(bus.rf_update_reg),   32'(vec[i].e_reg));
      if (vec[i].e_upd) begin
        chk($sformatf("v%0d rf_update_index", i), 32'(bus.rf_update_index), 32'(vec[i].e_idx));
        chk($sformatf("v%0d rf_update_data", i),  bus.rf_update_data,       vec[i].e_data);
      end
      chk($sformatf("v%0d store_commit_en", i), 32'(bus.store_commit_en), 32'(vec[i].e_st));
      chk($sformatf("v%0d flush_signal", i),    32'(bus.flush_signal),    32'(vec[i].e_fl));
      if (vec[i].e_fl)
        chk($sformatf("v%0d flush_pc", i),      bus.flush_pc,             vec[i].e_fpc);
      chk($sformatf("v%0d q1_ready", i),        32'(bus.q1_ready),        32'(vec[i].e_qr));
      chk($sformatf("v%0d q1_value", i),        bus.q1_value,             vec[i].e_qv);
      tick();
    end

    // Fill to full, ignored 9th issue, commit frees a slot, tail wraps.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(2'd0, 5'(i + 1), 1'b0, 1'b0, 32'h0);
      tick();
    end
    chk("fill full", 32'(bus.rob_full), 32'd1);
    chk("fill tail wrap", 32'(bus.rob_tail), 32'd0);
    issue(2'd0, 5'd31, 1'b0, 1'b1, 32'hDEAD);
    tick();
    chk("9th ignored tail", 32'(bus.rob_tail), 32'd0);
    chk("9th ignored full", 32'(bus.rob_full), 32'd1);
    cdb(3'd0, 32'h11, 1'b0, 32'h0);
    tick();
    issue(2'd0, 5'd30, 1'b0, 1'b1, 32'hBAD);
    #1;
    chk("full commit en", 32'(bus.rf_update_en), 32'd1);
    chk("full commit reg", 32'(bus.rf_update_reg), 32'd1);
    chk("full commit data", bus.rf_update_data, 32'h11);
    chk("full still full", 32'(bus.rob_full), 32'd1);
    tick();
    chk("after commit not full", 32'(bus.rob_full), 32'd0);
    chk("blocked alloc tail", 32'(bus.rob_tail), 32'd0);
    issue(2'd0, 5'd2, 1'b0, 1'b0, 32'h0);
    tick();
    chk("refill tail", 32'(bus.rob_tail), 32'd1);
    chk("refill full", 32'(bus.rob_full), 32'd1);

    // Branch mispredict flush, then a correctly predicted branch.
    do_reset();
    issue(2'd1, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    cdb(3'd0, 32'h0, 1'b1, 32'h80);
    tick();
    #1;
    chk("br commit en", 32'(bus.rf_update_en), 32'd1);
    chk("br commit reg", 32'(bus.rf_update_reg), 32'd0);
    chk("br no flush yet", 32'(bus.flush_signal), 32'd0);
    tick();
    #1;
    chk("br flush", 32'(bus.flush_signal), 32'd1);
    chk("br flush_pc", bus.flush_pc, 32'h80);
    chk("br flush no commit", 32'(bus.rf_update_en), 32'd0);
    tick();
    #1;
    chk("br after flush", 32'(bus.flush_signal), 32'd0);
    chk("br tail reset", 32'(bus.rob_tail), 32'd0);
    issue(2'd1, 5'd0, 1'b1, 1'b0, 32'h0);
    tick();
    cdb(3'd0, 32'h0, 1'b1, 32'h40);
    tick();
    tick();
    #1;
    chk("br correct no flush", 32'(bus.flush_signal), 32'd0);
    chk("br correct tail", 32'(bus.rob_tail), 32'd1);

    // Out-of-order completion retires in order.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(2'd0, 5'(10 + i), 1'b0, 1'b0, 32'h0);
      tick();
    end
    cdb(3'd3, 32'h103, 1'b0, 32'h0);
    tick();
    bus.q2_index = 3'd3;
    #1;
    chk("ooo no commit", 32'(bus.rf_update_en), 32'd0);
    chk("ooo q2_ready", 32'(bus.q2_ready), 32'd1);
    chk("ooo q2_value", bus.q2_value, 32'h103);
    cdb(3'd1, 32'h101, 1'b0, 32'h0);
    tick();
    cdb(3'd2, 32'h102, 1'b0, 32'h0);
    tick();
    #1;
    chk("ooo still waiting", 32'(bus.rf_update_en), 32'd0);
    cdb(3'd0, 32'h100, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ooo retire%0d en", i), 32'(bus.rf_update_en), 32'd1);
      chk($sformatf("ooo retire%0d idx", i), 32'(bus.rf_update_index), 32'(i));
      chk($sformatf("ooo retire%0d reg", i), 32'(bus.rf_update_reg), 32'(10 + i));
      chk($sformatf("ooo retire%0d data", i), bus.rf_update_data, 32'(32'h100 + i));
      tick();
    end
    #1;
    chk("ooo drained", 32'(bus.rf_update_en), 32'd0);

    // Store commit held off by rdy_in=0.
    do_reset();
    issue(2'd2, 5'd9, 1'b0, 1'b0, 32'h0);
    tick();
    cdb(3'd0, 32'h77, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      rdy = 1'b0;
      #1;
      chk($sformatf("st hold%0d st_en", i), 32'(bus.store_commit_en), 32'd0);
      chk($sformatf("st hold%0d upd_en", i), 32'(bus.rf_update_en), 32'd0);
      @(posedge clk);
      #1;
    end
    rdy = 1'b1;
    #1;
    chk("st commit st_en", 32'(bus.store_commit_en), 32'd1);
    chk("st commit reg", 32'(bus.rf_update_reg), 32'd0);
    chk("st commit data", bus.rf_update_data, 32'h77);
    chk("st commit idx", 32'(bus.rf_update_index), 32'd0);
    tick();
    #1;
    chk("st done st_en", 32'(bus.store_commit_en), 32'd0);
    chk("st done tail", 32'(bus.rob_tail), 32'd1);

`ifdef ROB_PERF_COUNTER_EN
    chk("perf commit_count", commit_count, 32'd1);
    chk("perf flush_count", flush_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
